// File: rtl/prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prefetch_pkg
// Brief   : Shared defaults and buffer-entry type for the instruction
//           prefetch unit.
// Revision: 1.0 - initial release
// ============================================================================
package prefetch_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_INSTR_W  = 18;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_RESET_PC = 0;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } pf_entry_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : prefetch_pkg
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : prefetch_fifo
// Brief   : Synchronous FIFO holding prefetched {pc, instr} entries. Flush
//           empties it in one edge and wins over push/pop. DEPTH must be a
//           power of two so the pointers wrap naturally.
// Revision: 1.0 - initial release
// ============================================================================
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_ADDR_W + DEF_INSTR_W,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Next-state: flush resets pointers; otherwise push and pop act independently.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; reset clears storage so the head reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule : prefetch_fifo
`default_nettype wire

// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : prefetch_unit
// Brief   : Sequential instruction prefetcher with credit-based request
//           throttling, a single-cycle memory response slot, redirect flush
//           and a FIFO buffer toward the consumer.
// Revision: 1.0 - initial release
// ============================================================================
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 INSTR_W  = DEF_INSTR_W,
    parameter int                 DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  pc_current
);

    localparam int c_cnt_w   = cnt_width(DEPTH);
    localparam int c_entry_w = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic                 inflight_q, inflight_d;
    logic [ADDR_W-1:0]    inflight_pc_q, inflight_pc_d;

    logic [c_cnt_w-1:0]   w_count;
    logic [c_cnt_w-1:0]   w_credit;
    logic                 w_empty;
    logic                 w_req;
    logic                 w_push;
    logic                 w_pop;
    logic [c_entry_w-1:0] w_head;

    // Buffered entries plus the outstanding response must never exceed DEPTH,
    // which guarantees the buffer has room when the response lands.
    assign w_credit = w_count + c_cnt_w'(inflight_q);
    assign w_req    = reset & fetch_en & ~redirect_valid
                    & (w_credit < c_cnt_w'(DEPTH));

    // A redirect kills the response arriving this cycle and hides the head.
    assign w_push    = inflight_q & ~redirect_valid;
    assign out_valid = ~w_empty & ~redirect_valid;
    assign w_pop     = out_valid & out_ready;

    // Fetch PC and in-flight slot: redirect overrides the sequential advance.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = w_req;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_addr;
        end else if (w_req) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
            inflight_pc_d = fetch_pc_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w),
        .CNT_W (c_cnt_w)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data ({inflight_pc_q, imem_rdata}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

    assign imem_req   = w_req;
    assign imem_addr  = fetch_pc_q;
    assign pc_current = fetch_pc_q;
    assign out_pc     = w_head[c_entry_w-1:INSTR_W];
    assign out_instr  = w_head[INSTR_W-1:0];

endmodule : prefetch_unit
`default_nettype wire

// File: tb/tb_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_prefetch_unit
// Brief   : Self-checking bench for prefetch_unit: directed scenarios plus a
//           randomized run, every cycle compared against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prefetch_unit;
    import prefetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic        out_ready;

    logic        req0, valid0, req1, valid1;
    logic [7:0]  addr0, pc0, cur0, addr1, pc1, cur1;
    logic [17:0] rdata0, instr0, rdata1, instr1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: every requested, not-yet-consumed, not-flushed address in order.
    typedef struct {
        pf_entry_t e;
        int        rc;
    } mentry_t;
    mentry_t    q[$];
    logic [7:0] mpc;
    int         cyc;

    // Values sampled in the most recent step for directed assertions.
    logic        s_req, s_valid, s1_valid;
    logic [7:0]  s_addr, s_pc, s1_pc;
    logic [17:0] s_instr, s1_instr;

    always #5 clk = ~clk;

    prefetch_unit #(.ADDR_W(8), .INSTR_W(18), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut0 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
        .out_valid(valid0), .out_ready(out_ready), .out_instr(instr0),
        .out_pc(pc0), .pc_current(cur0)
    );

    prefetch_unit #(.ADDR_W(8), .INSTR_W(18), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut1 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .out_valid(valid1), .out_ready(out_ready), .out_instr(instr1),
        .out_pc(pc1), .pc_current(cur1)
    );

    // One-cycle memories, mem[a] = a + 0x100; junk when no request was made.
    always_ff @(posedge clk) begin
        rdata0 <= req0 ? (18'(addr0) + 18'h100) : 18'h3ABCD;
        rdata1 <= req1 ? (18'(addr1) + 18'h100) : 18'h3ABCD;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc = 8'h00;
        cyc = 0;
    endtask

    // Called at posedge+1: applies inputs, checks at negedge, advances model.
    task automatic step(input logic fe, input logic rv, input logic [7:0] ra, input logic rdy);
        logic    exp_req, exp_valid;
        mentry_t ne;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_addr  = ra;
        out_ready      = rdy;
        @(negedge clk);
        exp_req   = fe && !rv && (q.size() < DEPTH);
        exp_valid = !rv && (q.size() > 0) && (q[0].rc + 2 <= cyc);
        check("imem_req", 32'(req0), 32'(exp_req));
        check("imem_addr", 32'(addr0), 32'(mpc));
        check("pc_current", 32'(cur0), 32'(mpc));
        check("out_valid", 32'(valid0), 32'(exp_valid));
        if (exp_valid) begin
            check("out_pc", 32'(pc0), 32'(q[0].e.pc));
            check("out_instr", 32'(instr0), 32'(q[0].e.instr));
        end
        s_req = req0; s_valid = valid0; s_addr = addr0; s_pc = pc0; s_instr = instr0;
        s1_valid = valid1; s1_pc = pc1; s1_instr = instr1;
        if (rv) begin
            q.delete();
            mpc = ra;
        end else begin
            if (exp_valid && rdy) void'(q.pop_front());
            if (exp_req) begin
                ne.e.pc    = mpc;
                ne.e.instr = 18'(mpc) + 18'h100;
                ne.rc      = cyc;
                q.push_back(ne);
                mpc = mpc + 8'd1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset_and_release();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(valid0), 32'd0);
        check("rst_imem_req", 32'(req0), 32'd0);
        check("rst_out_instr", 32'(instr0), 32'd0);
        check("rst_out_pc", 32'(pc0), 32'd0);
        check("rst_pc_current", 32'(cur0), 32'h00);
        check("rst_pc_current_fe", 32'(cur1), 32'hFE);
        check("rst_out_valid_fe", 32'(valid1), 32'd0);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int         n_req;
        logic [7:0] fe_pcs [4];
        fe_pcs[0] = 8'hFE; fe_pcs[1] = 8'hFF; fe_pcs[2] = 8'h00; fe_pcs[3] = 8'h01;

        reset = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0;
        redirect_addr = 8'h00; out_ready = 1'b1;
        model_reset();

        // Free run from reset; second instance starts at 0xFE and wraps.
        hold_reset_and_release();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            if (i >= 2 && i <= 5) begin
                check("fe_out_valid", 32'(s1_valid), 32'd1);
                check("fe_out_pc", 32'(s1_pc), 32'(fe_pcs[i-2]));
                check("fe_out_instr", 32'(s1_instr), 32'(18'(fe_pcs[i-2]) + 18'h100));
            end
        end

        // Consumer stalled: exactly DEPTH requests, then drain in order.
        hold_reset_and_release();
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            n_req += int'(s_req);
        end
        check("stall_req_count", 32'(n_req), 32'd4);
        check("stall_req_last", 32'(s_req), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Redirect with pc 5..7 buffered and 8 in flight.
        hold_reset_and_release();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("pre_redir_head", 32'(s_pc), 32'h05);
        step(1'b1, 1'b1, 8'h40, 1'b1);
        check("redir_valid_low", 32'(s_valid), 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("redir_next_req", 32'(s_req), 32'd1);
        check("redir_next_addr", 32'(s_addr), 32'h40);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("redir_killed", 32'(s_valid), 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("redir_first_valid", 32'(s_valid), 32'd1);
        check("redir_first_pc", 32'(s_pc), 32'h40);
        check("redir_first_instr", 32'(s_instr), 32'h140);

        // Redirect during push+pop, then back-to-back redirects.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        check("b2b_pre_valid", 32'(s_valid), 32'd1);
        step(1'b1, 1'b1, 8'h10, 1'b1);
        step(1'b1, 1'b1, 8'h20, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("b2b_empty", 32'(s_valid), 32'd0);
        check("b2b_addr", 32'(s_addr), 32'h20);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("b2b_first_pc", 32'(s_pc), 32'h20);
        check("b2b_first_valid", 32'(s_valid), 32'd1);

        // Asynchronous reset with a full buffer.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        check("full_pre_valid", 32'(valid0), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid0), 32'd0);
        check("async_rst_req", 32'(req0), 32'd0);
        hold_reset_and_release();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            if (i == 2) begin
                check("post_rst_valid", 32'(s_valid), 32'd1);
                check("post_rst_pc", 32'(s_pc), 32'h00);
            end
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_prefetch_unit
`default_nettype wire
